rp_trg_sched: RTL and testbench
===============================

# rp_trg_sched

Acquisition trigger scheduler for the ADC capture path. It sequences one acquisition: arm, pre-trigger fill, trigger arbitration, post-trigger fill and hold-off. It arbitrates simultaneous trigger requests from all sources. It drives the trigger-source code, the new-source strobe and the 2-bit data-delay select consumed by the ADC delay-alignment stage.

## Interface
Parameters:
- `CW`, default 32: width of the pre-, post- and hold-off counters.

Ports (name, direction, width, meaning). One clock; reset is asynchronous and active-high.
- `adc_clk_i`, in, 1: ADC clock, the only clock.
- `adc_rst_i`, in, 1: asynchronous, active-high reset.
- `arm_i`, in, 1: single-cycle pulse that starts an acquisition.
- `abort_i`, in, 1: single-cycle pulse that ends the acquisition immediately.
- `smp_val_i`, in, 1: decimated sample-valid strobe. The pre and post counters advance only on this strobe.
- `trg_req_i`, in, 14: trigger request per source code. Bit k means source k. Bit 0 is ignored.
- `trg_mask_i`, in, 14: per-source enable. A request counts only when its mask bit is 1.
- `pre_cnt_i`, in, CW: samples to collect before a trigger is accepted.
- `post_cnt_i`, in, CW: samples to collect after the trigger.
- `holdoff_i`, in, CW: clock cycles of dead time after post completes.
- `set_trg_src_o`, out, 4: latched code of the winning source.
- `set_trg_new_o`, out, 1: one-cycle strobe when a new source is latched.
- `dly_sel_o`, out, 2: data-delay select for the alignment stage.
- `acq_en_o`, out, 1: capture-buffer write enable.
- `state_o`, out, 3: current state encoding.
- `done_o`, out, 1: one-cycle pulse when post-trigger capture completes.

## Operation
States and encodings:
- IDLE = 0.
- PRE = 1.
- ARMED = 2.
- POST = 3.
- HOLD = 4.

Transitions:
- IDLE: `arm_i` latches `pre_cnt_i`, `post_cnt_i` and `holdoff_i` into shadow registers and clears the counter.
  - If the latched pre count is 0, go to ARMED.
  - Otherwise go to PRE.
- PRE: the counter increments on `smp_val_i`. When the counter reaches pre-1 and `smp_val_i` is high, go to ARMED.
- ARMED: compute the masked request vector `trg_req_i & trg_mask_i`, excluding bit 0.
  - If it is nonzero, the lowest set index wins (fixed priority).
  - Register the winner into `set_trg_src_o`, pulse `set_trg_new_o`, clear the counter and go to POST.
- POST: the counter increments on `smp_val_i`. On reaching post-1 with `smp_val_i` high, pulse `done_o` and go to HOLD.
  - If post is 0, leave POST on the first `smp_val_i`, which captures exactly one sample.
- HOLD: the counter increments every cycle. On reaching holdoff-1, go to IDLE.
  - If holdoff is 0, go to IDLE on the next cycle.

Delay-select mapping, updated on the same edge as `set_trg_new_o`:
- Codes 2–5 and 10–13 (level triggers): `dly_sel_o` = 1.
- Codes 6–9 (external and ASG): `dly_sel_o` = 2.
- Code 1 (manual) and all others: `dly_sel_o` holds its previous value.

Output rules:
- `acq_en_o` is 1 in PRE, ARMED and POST, and 0 in IDLE and HOLD.
- Requests outside ARMED are ignored. No queueing.
- `arm_i` outside IDLE is ignored.
- `abort_i` in any state goes to IDLE on the next edge. No `done_o` is produced and `set_trg_src_o` and `dly_sel_o` are unchanged. `abort_i` beats `arm_i` in the same cycle.
- Changing the `*_cnt_i` / `holdoff_i` inputs mid-acquisition has no effect, because shadow values are used.

Arithmetic:
- Counters are CW-bit unsigned and compared with `==`.
- Counters never wrap within a phase because the phase ends at the compare.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `set_trg_src_o` = 0, `set_trg_new_o` = 0, `dly_sel_o` = 0, `acq_en_o` = 0, `done_o` = 0, counter = 0.
- A trigger request present at edge N while in ARMED gives `set_trg_new_o` = 1, the new `set_trg_src_o` and the new `dly_sel_o` in the cycle after edge N. In that same cycle `state_o` = 3.
- `arm_i` at edge N gives `acq_en_o` = 1 after edge N.
- `done_o` is high for exactly one cycle, coincident with the first cycle of HOLD.
- Reset asserted mid-acquisition forces all outputs to their reset values immediately, without waiting for a clock edge.

## Configuration
- `RP_TRG_HOLDOFF_EN` defined: the HOLD state and `holdoff_i` are active as described above.
- `RP_TRG_HOLDOFF_EN` undefined:
  - POST completion goes straight to IDLE, with `done_o` in the first IDLE cycle.
  - `holdoff_i` is unused.
  - State encoding 4 never appears on `state_o`.

## Test plan
- Fixed priority: pre=0, mask=0x3FFE, arm, then assert `trg_req_i` bits 9 and 3 together → `set_trg_src_o` = 3, `dly_sel_o` = 1, `set_trg_new_o` high for 1 cycle.
- Pre and post counts: pre=4, post=8, `smp_val_i` every other cycle.
  - Requests during PRE are ignored.
  - ARMED is entered after 4 strobes.
  - A source-7 request gives `dly_sel_o` = 2.
  - `done_o` fires after 8 post strobes, and `acq_en_o` falls with it.
- Manual source: a prior level trigger leaves `dly_sel_o` = 1. Re-arm and request source 1 → `set_trg_src_o` = 1 and `dly_sel_o` stays 1.
- Abort: abort in POST after 3 of 8 samples → IDLE next cycle, no `done_o`, `acq_en_o` = 0. `arm_i` and `abort_i` in the same cycle → remains IDLE.
- Hold-off, with the macro defined: holdoff=5 → `state_o` = 4 for exactly 5 cycles. `arm_i` during HOLD is ignored. Without the macro → IDLE right after POST.
- Reset: assert `adc_rst_i` mid-ARMED, between clock edges → all outputs go to their reset values immediately. A masked request (mask bit 0) never triggers.

Source files
------------

// File: rtl/rp_trg_sched.sv
// Acquisition trigger scheduler: arm, pre-trigger fill, fixed-priority trigger
// arbitration, post-trigger fill and optional hold-off (RP_TRG_HOLDOFF_EN).
module rp_trg_sched #(
    parameter int CW = 32
) (
    input  logic          adc_clk_i,
    input  logic          adc_rst_i,
    input  logic          arm_i,
    input  logic          abort_i,
    input  logic          smp_val_i,
    input  logic [13:0]   trg_req_i,
    input  logic [13:0]   trg_mask_i,
    input  logic [CW-1:0] pre_cnt_i,
    input  logic [CW-1:0] post_cnt_i,
    input  logic [CW-1:0] holdoff_i,
    output logic [3:0]    set_trg_src_o,
    output logic          set_trg_new_o,
    output logic [1:0]    dly_sel_o,
    output logic          acq_en_o,
    output logic [2:0]    state_o,
    output logic          done_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pre_sh_q, pre_sh_d;
    logic [CW-1:0] post_sh_q, post_sh_d;
    logic [3:0]    src_q, src_d;
    logic [1:0]    dly_q, dly_d;
    logic          new_q, new_d;
    logic          done_q, done_d;
    logic          acq_q;
    logic [13:0]   req_m;
    logic [3:0]    win;
    logic          post_last;
`ifdef RP_TRG_HOLDOFF_EN
    logic [CW-1:0] hold_sh_q, hold_sh_d;
`else
    logic          unused_holdoff;
    assign unused_holdoff = ^holdoff_i;
`endif

    // Lowest set index wins; bit 0 is never a valid source.
    function automatic logic [3:0] prio_enc(input logic [13:0] v);
        logic [3:0] enc;
        enc = 4'd0;
        for (int k = 13; k >= 1; k--) begin
            if (v[k]) enc = 4'(k);
        end
        return enc;
    endfunction

    function automatic logic [1:0] dly_map(input logic [3:0] code, input logic [1:0] prev);
        logic [1:0] sel;
        sel = prev;
        if ((code >= 4'd2 && code <= 4'd5) || (code >= 4'd10 && code <= 4'd13)) sel = 2'd1;
        else if (code >= 4'd6 && code <= 4'd9) sel = 2'd2;
        return sel;
    endfunction

    assign req_m     = trg_req_i & trg_mask_i & 14'h3FFE;
    assign win       = prio_enc(req_m);
    assign post_last = (post_sh_q == '0) || (cnt_q == post_sh_q - CW'(1));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pre_sh_d  = pre_sh_q;
        post_sh_d = post_sh_q;
`ifdef RP_TRG_HOLDOFF_EN
        hold_sh_d = hold_sh_q;
`endif
        src_d     = src_q;
        dly_d     = dly_q;
        new_d     = 1'b0;
        done_d    = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arm_i) begin
                        pre_sh_d  = pre_cnt_i;
                        post_sh_d = post_cnt_i;
`ifdef RP_TRG_HOLDOFF_EN
                        hold_sh_d = holdoff_i;
`endif
                        cnt_d     = '0;
                        state_d   = (pre_cnt_i == '0) ? ARMED : PRE;
                    end
                end
                PRE: begin
                    if (smp_val_i) begin
                        if (cnt_q == pre_sh_q - CW'(1)) begin
                            state_d = ARMED;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ARMED: begin
                    if (req_m != '0) begin
                        src_d   = win;
                        dly_d   = dly_map(win, dly_q);
                        new_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = POST;
                    end
                end
                POST: begin
                    if (smp_val_i) begin
                        if (post_last) begin
                            done_d = 1'b1;
                            cnt_d  = '0;
`ifdef RP_TRG_HOLDOFF_EN
                            state_d = HOLD;
`else
                            state_d = IDLE;
`endif
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
`ifdef RP_TRG_HOLDOFF_EN
                HOLD: begin
                    if ((hold_sh_q == '0) || (cnt_q == hold_sh_q - CW'(1))) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
        if (adc_rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pre_sh_q  <= '0;
            post_sh_q <= '0;
`ifdef RP_TRG_HOLDOFF_EN
            hold_sh_q <= '0;
`endif
            src_q     <= 4'd0;
            dly_q     <= 2'd0;
            new_q     <= 1'b0;
            done_q    <= 1'b0;
            acq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pre_sh_q  <= pre_sh_d;
            post_sh_q <= post_sh_d;
`ifdef RP_TRG_HOLDOFF_EN
            hold_sh_q <= hold_sh_d;
`endif
            src_q     <= src_d;
            dly_q     <= dly_d;
            new_q     <= new_d;
            done_q    <= done_d;
            acq_q     <= (state_d == PRE) || (state_d == ARMED) || (state_d == POST);
        end
    end

    assign state_o       = state_q;
    assign set_trg_src_o = src_q;
    assign set_trg_new_o = new_q;
    assign dly_sel_o     = dly_q;
    assign acq_en_o      = acq_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_rp_trg_sched.sv
// Bench for rp_trg_sched: directed scenarios plus randomized traffic checked
// against a remaining-count phase model.
module tb_rp_trg_sched;

    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm, abort, smp;
    logic [13:0]   req, mask;
    logic [CW-1:0] pre, post, hold;
    logic [3:0]    src;
    logic          trg_new, acq, done;
    logic [1:0]    dly;
    logic [2:0]    st;

    int tests = 0;
    int fails = 0;

    // model state: phase uses the published state codes
    int       m_ph, m_left;
    int       m_post, m_hold;
    int       m_src, m_dly;
    bit       m_new, m_done;

    rp_trg_sched #(.CW(CW)) dut (
        .adc_clk_i    (clk),
        .adc_rst_i    (rst),
        .arm_i        (arm),
        .abort_i      (abort),
        .smp_val_i    (smp),
        .trg_req_i    (req),
        .trg_mask_i   (mask),
        .pre_cnt_i    (pre),
        .post_cnt_i   (post),
        .holdoff_i    (hold),
        .set_trg_src_o(src),
        .set_trg_new_o(trg_new),
        .dly_sel_o    (dly),
        .acq_en_o     (acq),
        .state_o      (st),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_ph = 0; m_left = 0; m_post = 0; m_hold = 0;
        m_src = 0; m_dly = 0; m_new = 0; m_done = 0;
    endtask

    task automatic model_step();
        int v;
        m_new  = 0;
        m_done = 0;
        if (abort) begin
            m_ph = 0;
        end else begin
            case (m_ph)
                0: if (arm) begin
                    m_post = int'(post);
                    m_hold = int'(hold);
                    if (pre == 0) m_ph = 2;
                    else begin m_ph = 1; m_left = int'(pre); end
                end
                1: if (smp) begin
                    m_left--;
                    if (m_left == 0) m_ph = 2;
                end
                2: begin
                    v = int'(req & mask) & 'h3FFE;
                    if (v != 0) begin
                        for (int k = 13; k >= 1; k--) if (v[k]) m_src = k;
                        if ((m_src >= 2 && m_src <= 5) || m_src >= 10) m_dly = 1;
                        else if (m_src >= 6 && m_src <= 9) m_dly = 2;
                        m_new  = 1;
                        m_ph   = 3;
                        m_left = (m_post == 0) ? 1 : m_post;
                    end
                end
                3: if (smp) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1;
`ifdef RP_TRG_HOLDOFF_EN
                        m_ph   = 4;
                        m_left = (m_hold == 0) ? 1 : m_hold;
`else
                        m_ph   = 0;
`endif
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_ph = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 0; abort = 0; smp = 0; req = '0;
    endtask

    task automatic wait_idle();
        int n;
        idle_inputs();
        smp = 1;
        n = 0;
        while (st !== 3'd0 && n < 100) begin
            tick();
            n++;
        end
        smp = 0;
        tests++;
        if (st !== 3'd0) begin
            fails++;
            $display("FAIL wait_idle: state=%0d required 0 within 100 cycles", st);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        mask = '0; pre = '0; post = '0; hold = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (st !== 3'd0)    begin fails++; $display("FAIL reset_state: got %0d need 0", st); end
        tests++; if (src !== 4'd0)   begin fails++; $display("FAIL reset_src: got %0d need 0", src); end
        tests++; if (trg_new !== 0)  begin fails++; $display("FAIL reset_new: got %0b need 0", trg_new); end
        tests++; if (dly !== 2'd0)   begin fails++; $display("FAIL reset_dly: got %0d need 0", dly); end
        tests++; if (acq !== 0)      begin fails++; $display("FAIL reset_acq: got %0b need 0", acq); end
        tests++; if (done !== 0)     begin fails++; $display("FAIL reset_done: got %0b need 0", done); end
        rst = 0;
    endtask

    task automatic test_priority();
        mask = 14'h3FFE; pre = 0; post = 2; hold = 0;
        arm = 1;
        tick();
        arm = 0;
        tests++; if (st !== 3'd2 || acq !== 1) begin fails++; $display("FAIL prio_armed: state=%0d acq=%0b need 2/1", st, acq); end
        req = (14'd1 << 9) | (14'd1 << 3);
        tick();
        req = '0;
        tests++; if (src !== 4'd3)   begin fails++; $display("FAIL prio_src: got %0d need 3", src); end
        tests++; if (dly !== 2'd1)   begin fails++; $display("FAIL prio_dly: got %0d need 1", dly); end
        tests++; if (trg_new !== 1 || st !== 3'd3) begin fails++; $display("FAIL prio_new: new=%0b state=%0d need 1/3", trg_new, st); end
        tick();
        tests++; if (trg_new !== 0)  begin fails++; $display("FAIL prio_new_pulse: got %0b need 0", trg_new); end
        wait_idle();
    endtask

    task automatic test_pre_post();
        mask = 14'h3FFE; pre = 4; post = 8; hold = 0;
        arm = 1;
        tick();
        arm = 0;
        tests++; if (st !== 3'd1 || acq !== 1) begin fails++; $display("FAIL pp_pre: state=%0d acq=%0b need 1/1", st, acq); end
        for (int i = 0; i < 8; i++) begin
            smp = i[0];
            req = 14'd1 << 7;
            tick();
            if (i == 5) begin
                tests++; if (st !== 3'd1) begin fails++; $display("FAIL pp_pre_hold: state=%0d need 1", st); end
            end
        end
        tests++; if (st !== 3'd2 || trg_new !== 0) begin fails++; $display("FAIL pp_armed: state=%0d new=%0b need 2/0", st, trg_new); end
        smp = 0;
        tick();
        req = '0;
        tests++; if (src !== 4'd7 || dly !== 2'd2 || trg_new !== 1) begin
            fails++; $display("FAIL pp_trig: src=%0d dly=%0d new=%0b need 7/2/1", src, dly, trg_new);
        end
        for (int i = 0; i < 16; i++) begin
            smp = i[0];
            tick();
            if (i < 15) begin
                tests++; if (done !== 0 || acq !== 1) begin fails++; $display("FAIL pp_post_%0d: done=%0b acq=%0b need 0/1", i, done, acq); end
            end
        end
        tests++; if (done !== 1 || acq !== 0) begin fails++; $display("FAIL pp_done: done=%0b acq=%0b need 1/0", done, acq); end
`ifdef RP_TRG_HOLDOFF_EN
        tests++; if (st !== 3'd4) begin fails++; $display("FAIL pp_after_post: state=%0d need 4", st); end
`else
        tests++; if (st !== 3'd0) begin fails++; $display("FAIL pp_after_post: state=%0d need 0", st); end
`endif
        smp = 0;
        tick();
        tests++; if (done !== 0) begin fails++; $display("FAIL pp_done_pulse: got %0b need 0", done); end
        wait_idle();
    endtask

    task automatic test_manual();
        mask = 14'h3FFE; pre = 0; post = 0; hold = 0;
        arm = 1; tick(); arm = 0;
        req = 14'd1 << 4; tick(); req = '0;
        tests++; if (dly !== 2'd1 || src !== 4'd4) begin fails++; $display("FAIL man_level: dly=%0d src=%0d need 1/4", dly, src); end
        smp = 1; tick(); smp = 0;
        tests++; if (done !== 1) begin fails++; $display("FAIL man_post0: done=%0b need 1", done); end
        wait_idle();
        arm = 1; tick(); arm = 0;
        req = 14'd1 << 1; tick(); req = '0;
        tests++; if (src !== 4'd1 || dly !== 2'd1 || trg_new !== 1) begin
            fails++; $display("FAIL man_src1: src=%0d dly=%0d new=%0b need 1/1/1", src, dly, trg_new);
        end
        wait_idle();
    endtask

    task automatic test_abort();
        mask = 14'h3FFE; pre = 0; post = 8; hold = 3;
        arm = 1; tick(); arm = 0;
        req = 14'd1 << 2; tick(); req = '0;
        smp = 1;
        repeat (3) tick();
        abort = 1;
        tick();
        abort = 0; smp = 0;
        tests++; if (st !== 3'd0 || acq !== 0 || done !== 0) begin
            fails++; $display("FAIL abort_post: state=%0d acq=%0b done=%0b need 0/0/0", st, acq, done);
        end
        tests++; if (src !== 4'd2 || dly !== 2'd1) begin fails++; $display("FAIL abort_keep: src=%0d dly=%0d need 2/1", src, dly); end
        tick();
        tests++; if (done !== 0) begin fails++; $display("FAIL abort_nodone: got %0b need 0", done); end
        arm = 1; abort = 1;
        tick();
        arm = 0; abort = 0;
        tests++; if (st !== 3'd0 || acq !== 0) begin fails++; $display("FAIL abort_beats_arm: state=%0d acq=%0b need 0/0", st, acq); end
    endtask

    task automatic test_holdoff();
        int n;
        mask = 14'h3FFE; pre = 0; post = 0; hold = 5;
        arm = 1; tick(); arm = 0;
        req = 14'd1 << 5; tick(); req = '0;
        smp = 1; tick(); smp = 0;
`ifdef RP_TRG_HOLDOFF_EN
        n = (st === 3'd4) ? 1 : 0;
        arm = 1;
        for (int i = 0; i < 20 && st === 3'd4; i++) begin
            tick();
            if (st === 3'd4) n++;
        end
        tests++; if (n != 5) begin fails++; $display("FAIL hold_len: %0d cycles need 5", n); end
        tests++; if (st !== 3'd0 || acq !== 0) begin fails++; $display("FAIL hold_arm_ignored: state=%0d acq=%0b need 0/0", st, acq); end
        arm = 0;
`else
        n = 0;
        tests++; if (st !== 3'd0 || done !== 1) begin fails++; $display("FAIL nohold_idle: state=%0d done=%0b need 0/1", st, done); end
`endif
        wait_idle();
    endtask

    task automatic test_async_reset();
        mask = 14'h3FFE; pre = 0; post = 4; hold = 0;
        arm = 1; tick(); arm = 0;
        #3;
        rst = 1;
        #1;
        tests++; if (st !== 3'd0 || acq !== 0 || src !== 4'd0 || dly !== 2'd0 || trg_new !== 0 || done !== 0) begin
            fails++; $display("FAIL async_reset: state=%0d acq=%0b src=%0d dly=%0d new=%0b done=%0b need all 0", st, acq, src, dly, trg_new, done);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        mask = 14'h3FFE & ~(14'd1 << 6);
        arm = 1; tick(); arm = 0;
        req = 14'h0041;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (st !== 3'd2 || trg_new !== 0) begin fails++; $display("FAIL masked_req_%0d: state=%0d new=%0b need 2/0", i, st, trg_new); end
        end
        req = '0; abort = 1; tick(); abort = 0;
        tests++; if (st !== 3'd0) begin fails++; $display("FAIL masked_abort: state=%0d need 0", st); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            arm   = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 99) == 0);
            smp   = ($urandom_range(0, 2) != 0);
            req   = ($urandom_range(0, 5) == 0) ? 14'($urandom) : 14'd0;
            mask  = 14'($urandom);
            pre   = $urandom_range(0, 5);
            post  = $urandom_range(0, 5);
            hold  = $urandom_range(0, 4);
            tick();
            tests++; if (st !== 3'(m_ph))     begin fails++; $display("FAIL rnd_state c%0d: got %0d need %0d", c, st, m_ph); end
            tests++; if (src !== 4'(m_src))   begin fails++; $display("FAIL rnd_src c%0d: got %0d need %0d", c, src, m_src); end
            tests++; if (dly !== 2'(m_dly))   begin fails++; $display("FAIL rnd_dly c%0d: got %0d need %0d", c, dly, m_dly); end
            tests++; if (trg_new !== m_new)   begin fails++; $display("FAIL rnd_new c%0d: got %0b need %0b", c, trg_new, m_new); end
            tests++; if (done !== m_done)     begin fails++; $display("FAIL rnd_done c%0d: got %0b need %0b", c, done, m_done); end
            tests++; if (acq !== (m_ph >= 1 && m_ph <= 3)) begin fails++; $display("FAIL rnd_acq c%0d: got %0b phase %0d", c, acq, m_ph); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_pre_post();
        test_manual();
        test_abort();
        test_holdoff();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
